uart_rx_fifo: RTL

Receive-side buffer between the UART `Receiver` and the host/bus logic. Accepts each frame's data byte and parity bit on the receiver's one-cycle `data_ready` pulse, checks parity, and stores byte plus error flag in a first-word-fall-through FIFO. Maintains sticky overflow status and a saturating parity-error counter, so no received byte is silently lost or corrupted.

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : parity-checking FWFT receive buffer with overflow/perr    |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_parity,
  input  logic              rx_valid,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        parity_err_cnt,
  input  logic              clr_status
);

  localparam logic [ADDR_W:0]   C_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);
  localparam logic [7:0]        C_ERR_MAX = 8'hFF;

  logic [8:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        perr_cnt_q, perr_cnt_d;

  logic w_empty;
  logic w_full;
  logic w_perr;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == C_DEPTH);

  // A frame is in error when its total ones-parity differs from the expected sense.
  assign w_perr  = (^rx_data) ^ rx_parity ^ PARITY_ODD;

  assign w_pop   = rd_en && !w_empty;
  assign w_wr    = rx_valid && (!w_full || w_pop);
  assign w_drop  = rx_valid && w_full && !w_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    perr_cnt_d = perr_cnt_q;

    if (w_wr) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end

    unique case ({w_wr, w_pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    // Clear first so that an event in the same cycle re-sets the status.
    if (clr_status) begin
      overflow_d = 1'b0;
      perr_cnt_d = 8'h00;
    end
    if (w_drop) begin
      overflow_d = 1'b1;
    end
    if (rx_valid && w_perr && (perr_cnt_d != C_ERR_MAX)) begin
      perr_cnt_d = perr_cnt_d + 8'h01;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      perr_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  // Storage needs no reset: stale entries are masked while the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    if (!reset && w_wr) begin
      mem_q[wr_ptr_q] <= {w_perr, rx_data};
    end
  end

  assign rd_data        = w_empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
  assign rd_err         = w_empty ? 1'b0  : mem_q[rd_ptr_q][8];
  assign empty          = w_empty;
  assign full           = w_full;
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign parity_err_cnt = perr_cnt_q;

endmodule
`default_nettype wire
